// File: rtl/dtree_seq_classifier.sv
// Sequential decision-tree classifier: walks a writable node table one node per cycle.
// Optional depth guard enabled by defining DTREE_DEPTH_GUARD_EN.
`timescale 1ns/1ps
module dtree_seq_classifier #(
  parameter int NUM_FEAT  = 7,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 5,
  parameter int NODE_AW   = 6,
  parameter int DEPTH_W   = 4,
  parameter int MAX_DEPTH = 15,
  localparam int FIDX_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
  localparam int PREC_W   = $clog2(FEAT_W) + 1,
  localparam int NODE_W   = 1 + FIDX_W + PREC_W + FEAT_W + 2 * NODE_AW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0]   in_feat,
  input  logic                         cfg_we,
  input  logic [NODE_AW-1:0]           cfg_addr,
  input  logic [NODE_W-1:0]            cfg_wdata,
  output logic                         cfg_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic [DEPTH_W-1:0]           out_depth,
  output logic                         out_err
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};

  state_t                       state_q, state_d;
  logic [NODE_W-1:0]            table_q [2**NODE_AW];
  logic [NUM_FEAT*FEAT_W-1:0]   feat_q;
  logic [NODE_AW-1:0]           ptr_q, ptr_d;
  logic [DEPTH_W-1:0]           depth_q, depth_d;
  logic [CLASS_W-1:0]           class_q, class_d;
  logic [DEPTH_W-1:0]           odepth_q, odepth_d;
  logic                         cfg_ack_q;
  logic                         cfg_wr;

  logic [NODE_W-1:0]            node;
  logic                         n_leaf;
  logic [FIDX_W-1:0]            n_fidx;
  logic [PREC_W-1:0]            n_prec;
  logic [FEAT_W-1:0]            n_thresh, fval, pmask;
  logic [NODE_AW-1:0]           n_left, n_right;
  logic                         go_left;

  // Keeps only the top P bits; P of 0 or above FEAT_W means the full width.
  function automatic logic [FEAT_W-1:0] prec_mask(input logic [PREC_W-1:0] p);
    int pi;
    prec_mask = '0;
    pi = int'(p);
    if (pi == 0 || pi > FEAT_W) pi = FEAT_W;
    for (int b = 0; b < FEAT_W; b++) prec_mask[b] = (b >= FEAT_W - pi);
  endfunction

  function automatic logic [FEAT_W-1:0] sel_feat(input logic [NUM_FEAT*FEAT_W-1:0] f,
                                                 input logic [FIDX_W-1:0] idx);
    sel_feat = f[FEAT_W-1:0];
    for (int i = 1; i < NUM_FEAT; i++)
      if (int'(idx) == i) sel_feat = f[i*FEAT_W +: FEAT_W];
  endfunction

  function automatic logic [DEPTH_W-1:0] sat_inc(input logic [DEPTH_W-1:0] d);
    sat_inc = (d == '1) ? d : d + 1'b1;
  endfunction

  assign cfg_wr    = cfg_we && (state_q == IDLE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_class = class_q;
  assign out_depth = odepth_q;
  assign cfg_ack   = cfg_ack_q;

  assign node     = table_q[ptr_q];
  assign n_leaf   = node[NODE_W-1];
  assign n_fidx   = node[NODE_W-2 -: FIDX_W];
  assign n_prec   = node[NODE_W-2-FIDX_W -: PREC_W];
  assign n_thresh = node[2*NODE_AW+FEAT_W-1 -: FEAT_W];
  assign n_left   = node[2*NODE_AW-1 -: NODE_AW];
  assign n_right  = node[NODE_AW-1:0];
  assign fval     = sel_feat(feat_q, n_fidx);
  assign pmask    = prec_mask(n_prec);
  assign go_left  = (fval & pmask) <= (n_thresh & pmask);

`ifdef DTREE_DEPTH_GUARD_EN
  logic err_q, err_d;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    depth_d  = depth_q;
    class_d  = class_q;
    odepth_d = odepth_q;
`ifdef DTREE_DEPTH_GUARD_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EVAL;
          ptr_d   = '0;
          depth_d = '0;
        end
      end
      EVAL: begin
        if (n_leaf) begin
          class_d  = node[CLASS_W-1:0];
          odepth_d = depth_q;
`ifdef DTREE_DEPTH_GUARD_EN
          err_d    = 1'b0;
`endif
          state_d  = DONE;
        end
`ifdef DTREE_DEPTH_GUARD_EN
        else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          class_d  = '1;
          odepth_d = DEPTH_W'(MAX_DEPTH);
          err_d    = 1'b1;
          state_d  = DONE;
        end
`endif
        else begin
          ptr_d   = go_left ? n_left : n_right;
          depth_d = sat_inc(depth_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      depth_q   <= '0;
      class_q   <= '0;
      odepth_q  <= '0;
      cfg_ack_q <= 1'b0;
`ifdef DTREE_DEPTH_GUARD_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      depth_q   <= depth_d;
      class_q   <= class_d;
      odepth_q  <= odepth_d;
      cfg_ack_q <= cfg_wr;
`ifdef DTREE_DEPTH_GUARD_EN
      err_q     <= err_d;
`endif
    end
  end

  // Table writes land on the accepting edge, so traversal sees them next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**NODE_AW; i++) table_q[i] <= LEAF0;
    end else if (cfg_wr) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) feat_q <= in_feat;
  end

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// Directed bench for dtree_seq_classifier; checks follow the DTREE_DEPTH_GUARD_EN build setting.
`timescale 1ns/1ps
module tb_dtree_seq_classifier;
  localparam int NUM_FEAT = 7;
  localparam int FEAT_W   = 8;
  localparam int CLASS_W  = 5;
  localparam int NODE_AW  = 6;
  localparam int DEPTH_W  = 4;
  localparam int NODE_W   = 28;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_FEAT*FEAT_W-1:0] in_feat;
  logic                       cfg_we;
  logic [NODE_AW-1:0]         cfg_addr;
  logic [NODE_W-1:0]          cfg_wdata;
  logic                       cfg_ack;
  logic                       out_valid;
  logic                       out_ready;
  logic [CLASS_W-1:0]         out_class;
  logic [DEPTH_W-1:0]         out_depth;
  logic                       out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtree_seq_classifier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_depth(out_depth), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NODE_W-1:0] inode(input logic [2:0] fidx, input logic [3:0] prec,
      input logic [7:0] th, input logic [5:0] l, input logic [5:0] r);
    return {1'b0, fidx, prec, th, l, r};
  endfunction

  function automatic logic [NODE_W-1:0] leaf(input logic [4:0] c);
    return {1'b1, 22'b0, c};
  endfunction

  function automatic logic [55:0] fv(input logic [7:0] x0, x1, x2, x3, x4, x5, x6);
    return {x6, x5, x4, x3, x2, x1, x0};
  endfunction

  task automatic cfg_write(input logic [5:0] a, input logic [NODE_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    check("cfg_ack_idle", cfg_ack, 1);
  endtask

  // Accept one vector, wait for the result, compare, then consume it.
  task automatic run(input string tag, input logic [55:0] f, input logic [4:0] ec,
                     input logic [3:0] ed, input logic ee, input int lat);
    int n;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_feat = f;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_class"}, out_class, ec);
    check({tag, "_depth"}, out_depth, ed);
    check({tag, "_err"}, out_err, ee);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_class", out_class, 0);
    check("rst_depth", out_depth, 0);
    check("rst_err", out_err, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    step();
    rst_n = 1'b1;
    step();

    // Empty table: root is leaf class 0
    run("empty", fv(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE), 5'd0, 4'd0, 1'b0, 1);

    // Two-leaf tree, root written on the same edge that accepts the vector
    cfg_write(6'd1, leaf(5'd5));
    cfg_write(6'd2, leaf(5'd25));
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = inode(3'd6, 4'd3, 8'h00, 6'd1, 6'd2);
    in_valid = 1'b1; in_feat = fv(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F);
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    check("same_edge_ack", cfg_ack, 1);
    check("same_edge_busy", in_ready, 0);
    step();
    check("same_edge_not_yet", out_valid, 0);
    step();
    check("same_edge_valid", out_valid, 1);
    check("same_edge_class", out_class, 5);
    check("same_edge_depth", out_depth, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    run("x6_20", fv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20), 5'd25, 4'd1, 1'b0, 2);
    run("x6_1f", fv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F), 5'd5, 4'd1, 1'b0, 2);

    // Write attempted during EVAL is dropped
    in_valid = 1'b1; in_feat = fv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F);
    step();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = leaf(5'd9);
    step();
    cfg_we = 1'b0;
    check("eval_wr_ack", cfg_ack, 0);
    step();
    check("eval_wr_valid", out_valid, 1);
    check("eval_wr_old_class", out_class, 5);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    cfg_write(6'd1, leaf(5'd9));
    step();
    check("cfg_ack_pulse", cfg_ack, 0);
    run("new_leaf", fv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F), 5'd9, 4'd1, 1'b0, 2);
    cfg_write(6'd1, leaf(5'd5));

    // Precision field: 0 and >FEAT_W mean full width, 1 means MSB only
    cfg_write(6'd0, inode(3'd2, 4'd0, 8'h80, 6'd1, 6'd2));
    run("p0_eq", fv(8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00), 5'd5, 4'd1, 1'b0, 2);
    run("p0_gt", fv(8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00), 5'd25, 4'd1, 1'b0, 2);
    cfg_write(6'd0, inode(3'd2, 4'd1, 8'h80, 6'd1, 6'd2));
    run("p1_msb", fv(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), 5'd5, 4'd1, 1'b0, 2);
    cfg_write(6'd0, inode(3'd2, 4'd9, 8'h80, 6'd1, 6'd2));
    run("p9_full", fv(8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00), 5'd25, 4'd1, 1'b0, 2);

    // Out-of-range feature index falls back to feature 0
    cfg_write(6'd0, inode(3'd7, 4'd0, 8'h10, 6'd1, 6'd2));
    run("fidx7_le", fv(8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 5'd5, 4'd1, 1'b0, 2);
    run("fidx7_gt", fv(8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5'd25, 4'd1, 1'b0, 2);

    // Depth-2 path: node0 -> node3 -> node2
    cfg_write(6'd3, inode(3'd1, 4'd0, 8'h40, 6'd1, 6'd2));
    cfg_write(6'd0, inode(3'd0, 4'd0, 8'h80, 6'd3, 6'd2));
    run("depth2", fv(8'h10, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5'd25, 4'd2, 1'b0, 3);

    // Back-pressure in DONE
    in_valid = 1'b1; in_feat = fv(8'h10, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    in_feat = fv(8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    seen = 0;
    while (!out_valid && seen < 20) begin step(); seen++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_class", out_class, 25);
      check("hold_busy", in_ready, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_release", out_valid, 0);
    step();
    check("hold_no_accept", in_ready, 1);

    // Self-loop at the root
    cfg_write(6'd0, inode(3'd0, 4'd0, 8'h00, 6'd0, 6'd0));
`ifdef DTREE_DEPTH_GUARD_EN
    run("guard", fv(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5'd31, 4'd15, 1'b1, 16);
    in_valid = 1'b1; in_feat = '0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
`else
    in_valid = 1'b1; in_feat = '0;
    step();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("loop_no_valid", seen, 0);
`endif

    // Reset mid-EVAL
    check("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_class", out_class, 0);
    check("mid_rst_depth", out_depth, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_ack", cfg_ack, 0);
    check("mid_rst_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("post_rst_no_valid", seen, 0);
    run("post_rst", fv(8'h10, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20), 5'd0, 4'd0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dtree_seq_classifier.md
DTREE_SEQ_CLASSIFIER -- requirements
Module: dtree_seq_classifier

Interface
REQ-001 SHALL provide parameter NUM_FEAT, default 7, number of input features.
REQ-002 SHALL provide parameter FEAT_W, default 8, feature and threshold width in bits.
REQ-003 SHALL provide parameter CLASS_W, default 5, class label width.
REQ-004 SHALL provide parameter NODE_AW, default 6, node-table address width (2**NODE_AW nodes).
REQ-005 SHALL provide parameter DEPTH_W, default 4, traversal depth counter width.
REQ-006 SHALL provide parameter MAX_DEPTH, default 15, internal-node limit for the depth guard.
REQ-007 SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-008 Ports, in this order:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  in_valid  in  1  feature vector valid
  in_ready  out  1  block can accept a vector
  in_feat  in  NUM_FEAT*FEAT_W  features; feature i occupies bits [i*FEAT_W +: FEAT_W]
  cfg_we  in  1  node-table write strobe
  cfg_addr  in  NODE_AW  node index
  cfg_wdata  in  NODE_W  node word
  cfg_ack  out  1  write accepted
  out_valid  out  1  result valid
  out_ready  in  1  result consumed
  out_class  out  CLASS_W  class label
  out_depth  out  DEPTH_W  internal nodes visited
  out_err  out  1  traversal aborted
REQ-009 Node word, MSB to LSB: leaf(1), fidx(clog2 NUM_FEAT), prec(clog2 FEAT_W + 1), thresh(FEAT_W), left(NODE_AW), right(NODE_AW); NODE_W is their sum (28 at defaults). For leaf=1 the class is cfg_wdata[CLASS_W-1:0] and all other fields are ignored.

Function
REQ-010 FSM states: IDLE, EVAL, DONE; in_ready SHALL equal (state==IDLE).
REQ-011 IDLE: in_valid&&in_ready SHALL latch in_feat, set node pointer to 0 and depth to 0, and move to EVAL.
REQ-012 EVAL: each cycle SHALL evaluate exactly one node, read combinationally from the table.
REQ-013 Internal node: with P = prec (P=0 or P>FEAT_W means FEAT_W), compare unsigned feat[fidx][FEAT_W-1 -: P] <= thresh[FEAT_W-1 -: P]; true -> pointer=left, false -> pointer=right; depth increments, saturating at all ones.
REQ-014 fidx >= NUM_FEAT SHALL select feature 0.
REQ-015 Leaf node: SHALL load out_class, load out_depth, clear out_err, and move to DONE.
REQ-016 DONE: out_valid=1 with outputs held stable until out_ready=1, then -> IDLE in the same edge.
REQ-017 Latency: vector accepted on edge t, leaf at depth d -> out_valid high after edge t+d+1.
REQ-018 cfg_we in IDLE SHALL write the node at cfg_addr and pulse cfg_ack for one cycle; cfg_we in EVAL/DONE SHALL be ignored with cfg_ack=0.
REQ-019 cfg_we and input acceptance on the same IDLE edge: the write SHALL take effect, and traversal SHALL use the updated table.
REQ-020 Tree cycles are legal inputs; behaviour is governed by REQ-025/026.

Reset
REQ-021 rst_n low SHALL force IDLE and clear out_valid, out_class, out_depth, out_err, and cfg_ack to 0.
REQ-022 Reset SHALL set every node to leaf=1 with class 0.
REQ-023 Reset mid-EVAL or in DONE SHALL discard the result; no out_valid follows.
REQ-024 Latched features need no reset.

Configuration
REQ-025 With DTREE_DEPTH_GUARD_EN defined: when an internal node is reached with depth==MAX_DEPTH, SHALL go to DONE with out_err=1, out_class=all ones, and out_depth=MAX_DEPTH.
REQ-026 Without DTREE_DEPTH_GUARD_EN: out_err SHALL be tied to 0, no limit SHALL apply, and a cyclic tree SHALL leave the block in EVAL indefinitely.

Verification
REQ-027 Reset, then any vector -> out_class=0, out_depth=0, out_err=0, out_valid 1 cycle after acceptance.
REQ-028 Node0 = internal (fidx=6, prec=3, thresh=0x00, left=1, right=2), node1 = leaf class 5, node2 = leaf class 25: X6=0x1F -> class 5, depth 1; X6=0x20 -> class 25, depth 1.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_class stable, in_ready=0, and a new in_valid is not accepted.
REQ-030 Node0 = internal with left=right=0 -> with macro: out_err=1, class 31, depth 15 after 16 EVAL cycles; without macro: no out_valid within 100 cycles.
REQ-031 cfg_we to node1 during EVAL -> cfg_ack=0, the old class is returned, and a subsequent IDLE write is acknowledged.
REQ-032 Assert rst_n=0 mid-EVAL -> all outputs 0, the table returns to all leaf-0, and the next vector yields class 0.
